// File: rtl/gdsp_tmds_pkg.sv
// ---------------------------------------------------------------------------
// gdsp_tmds_pkg
// Shared TMDS definitions for the DVI transmit encoder and receive decoder.
//   TMDS_CTRL_00..11  : the four 10-bit control tokens, indexed by {c1,c0}
//   tmds_rx_state_t   : receive word-alignment state machine states
//   is_ctrl_token(w)  : returns {valid, ctl[1:0]} for a raw 10-bit word
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
package gdsp_tmds_pkg;

    localparam logic [9:0] TMDS_CTRL_00 = 10'b1101010100;
    localparam logic [9:0] TMDS_CTRL_01 = 10'b0010101011;
    localparam logic [9:0] TMDS_CTRL_10 = 10'b0101010100;
    localparam logic [9:0] TMDS_CTRL_11 = 10'b1010101011;

    typedef enum logic [1:0] {
        SEARCH    = 2'd0,
        SLIP_WAIT = 2'd1,
        LOCKED    = 2'd2
    } tmds_rx_state_t;

    // {valid, c1, c0}; valid=0 for anything that is not an exact control token.
    function automatic logic [2:0] is_ctrl_token(input logic [9:0] w);
        logic [2:0] result;
        case (w)
            TMDS_CTRL_00: result = 3'b100;
            TMDS_CTRL_01: result = 3'b101;
            TMDS_CTRL_10: result = 3'b110;
            TMDS_CTRL_11: result = 3'b111;
            default:      result = 3'b000;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/tmds_symbol_decode.sv
// ---------------------------------------------------------------------------
// tmds_symbol_decode
// Purely combinational 10b->8b TMDS symbol decode plus control-token detect.
// Shared by all three channel receive paths.
//   tmds_word  in  10  raw aligned TMDS symbol, bit 0 first on the wire
//   is_ctrl    out 1   word is one of the four control tokens
//   ctl        out 2   control value {c1,c0} (meaningful when is_ctrl=1)
//   data       out 8   decoded byte (meaningful when is_ctrl=0)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tmds_symbol_decode
    import gdsp_tmds_pkg::*;
(
    input  logic [9:0] tmds_word,
    output logic       is_ctrl,
    output logic [1:0] ctl,
    output logic [7:0] data
);

    logic [2:0] token;
    logic [7:0] d_unmasked;

    assign token   = is_ctrl_token(tmds_word);
    assign is_ctrl = token[2];
    assign ctl     = token[1:0];

    // Bit 9 flags that the encoder inverted the payload for DC balance.
    assign d_unmasked = tmds_word[9] ? ~tmds_word[7:0] : tmds_word[7:0];

    // Bit 8 selects XOR (1) or XNOR (0) chaining between adjacent bits.
    assign data[0] = d_unmasked[0];
    generate
        for (genvar gi = 1; gi < 8; gi++) begin : g_chain
            assign data[gi] = tmds_word[8] ? (d_unmasked[gi] ^ d_unmasked[gi-1])
                                           : ~(d_unmasked[gi] ^ d_unmasked[gi-1]);
        end
    endgenerate

endmodule

// File: rtl/tmds_rx_decoder.sv
// ---------------------------------------------------------------------------
// tmds_rx_decoder
// One TMDS channel receive path: word alignment (by pulsing the IDES10 CALIB
// bitslip input) and 10b->8b decode, all in the pixel clock domain.
//   clk_pixel      in  1   pixel clock (IDES10 PCLK)
//   rst_n          in  1   asynchronous active-low reset
//   tmds_word      in  10  raw parallel word from IDES10, bit 0 first
//   bitslip        out 1   one-cycle pulse: shift word boundary by one bit
//   locked         out 1   word alignment established
//   de             out 1   1 = data symbol decoded, 0 = control period
//   ctl            out 2   control bits during blanking ({vsync,hsync} on blue)
//   data           out 8   decoded pixel byte, valid when de=1
//   slip_cnt       out 4   current slip position 0..9, wraps 9->0
//   lock_loss_cnt  out 8   saturating count of LOCKED->SEARCH transitions
// Alignment is declared after CTRL_RUN_MIN consecutive control tokens. While
// locked, each fresh run of CTRL_RUN_MIN tokens refreshes a loss watchdog.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tmds_rx_decoder
    import gdsp_tmds_pkg::*;
#(
    parameter int CTRL_RUN_MIN   = 8,
    parameter int SEARCH_TIMEOUT = 1024,
    parameter int SLIP_SETTLE    = 16,
    parameter int LOSS_TIMEOUT   = 2048
) (
    input  logic       clk_pixel,
    input  logic       rst_n,
    input  logic [9:0] tmds_word,
    output logic       bitslip,
    output logic       locked,
    output logic       de,
    output logic [1:0] ctl,
    output logic [7:0] data,
    output logic [3:0] slip_cnt,
    output logic [7:0] lock_loss_cnt
);

    // One timer serves all three states, so it is sized for the longest timeout.
    localparam int MAX_A   = (SEARCH_TIMEOUT > SLIP_SETTLE) ? SEARCH_TIMEOUT : SLIP_SETTLE;
    localparam int MAX_TO  = (MAX_A > LOSS_TIMEOUT) ? MAX_A : LOSS_TIMEOUT;
    localparam int TMR_W   = $clog2(MAX_TO);
    localparam int RUN_W   = $clog2(CTRL_RUN_MIN + 1);

    localparam logic [TMR_W-1:0] SEARCH_LAST = TMR_W'(SEARCH_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SLIP_SETTLE - 1);
    localparam logic [TMR_W-1:0] LOSS_LAST   = TMR_W'(LOSS_TIMEOUT - 1);
    localparam logic [RUN_W-1:0] RUN_MAX     = RUN_W'(CTRL_RUN_MIN);
    localparam logic [RUN_W-1:0] RUN_HIT_VAL = RUN_W'(CTRL_RUN_MIN - 1);

    tmds_rx_state_t   state_reg;
    logic [TMR_W-1:0] tmr_reg;
    logic [RUN_W-1:0] run_cnt_reg;
    logic             bitslip_reg;
    logic             locked_reg;
    logic             de_reg;
    logic [1:0]       ctl_reg;
    logic [7:0]       data_reg;
    logic [3:0]       slip_cnt_reg;
    logic [7:0]       lock_loss_cnt_reg;

    logic             sym_is_ctrl;
    logic [1:0]       sym_ctl;
    logic [7:0]       sym_data;
    logic             run_hit;
    logic             lock_next;

    tmds_symbol_decode u_symbol_decode (
        .tmds_word (tmds_word),
        .is_ctrl   (sym_is_ctrl),
        .ctl       (sym_ctl),
        .data      (sym_data)
    );

    // lock_next is the state being entered this edge; the output registers are
    // gated by it so decoded outputs appear on the same cycle locked rises and
    // are zeroed on the same cycle locked falls.
    always_comb begin
        run_hit   = sym_is_ctrl && (run_cnt_reg == RUN_HIT_VAL);
        lock_next = 1'b0;
        case (state_reg)
            SEARCH:  lock_next = run_hit;
            LOCKED:  lock_next = run_hit || (tmr_reg != LOSS_LAST);
            default: lock_next = 1'b0;
        endcase
    end

    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            state_reg         <= SEARCH;
            tmr_reg           <= '0;
            run_cnt_reg       <= '0;
            bitslip_reg       <= 1'b0;
            locked_reg        <= 1'b0;
            de_reg            <= 1'b0;
            ctl_reg           <= 2'b00;
            data_reg          <= 8'h00;
            slip_cnt_reg      <= 4'd0;
            lock_loss_cnt_reg <= 8'h00;
        end else begin
            bitslip_reg <= 1'b0;

            // Token run length, saturating; any data word breaks the run.
            if (!sym_is_ctrl) begin
                run_cnt_reg <= '0;
            end else if (run_cnt_reg != RUN_MAX) begin
                run_cnt_reg <= run_cnt_reg + 1'b1;
            end

            case (state_reg)
                SEARCH: begin
                    if (run_hit) begin
                        state_reg <= LOCKED;
                        tmr_reg   <= '0;
                    end else if (tmr_reg == SEARCH_LAST) begin
                        bitslip_reg  <= 1'b1;
                        slip_cnt_reg <= (slip_cnt_reg == 4'd9) ? 4'd0 : slip_cnt_reg + 4'd1;
                        tmr_reg      <= '0;
                        run_cnt_reg  <= '0;
                        state_reg    <= SLIP_WAIT;
                    end else begin
                        tmr_reg <= tmr_reg + 1'b1;
                    end
                end
                SLIP_WAIT: begin
                    // Words are unreliable while the IDES10 realigns.
                    run_cnt_reg <= '0;
                    if (tmr_reg == SETTLE_LAST) begin
                        state_reg <= SEARCH;
                        tmr_reg   <= '0;
                    end else begin
                        tmr_reg <= tmr_reg + 1'b1;
                    end
                end
                LOCKED: begin
                    if (run_hit) begin
                        tmr_reg <= '0;
                    end else if (tmr_reg == LOSS_LAST) begin
                        state_reg <= SEARCH;
                        tmr_reg   <= '0;
                        if (lock_loss_cnt_reg != 8'hFF) begin
                            lock_loss_cnt_reg <= lock_loss_cnt_reg + 8'd1;
                        end
                    end else begin
                        tmr_reg <= tmr_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= SEARCH;
                    tmr_reg   <= '0;
                end
            endcase

            locked_reg <= lock_next;
            if (lock_next) begin
                if (sym_is_ctrl) begin
                    de_reg  <= 1'b0;
                    ctl_reg <= sym_ctl;
                end else begin
                    de_reg   <= 1'b1;
                    data_reg <= sym_data;
                end
            end else begin
                de_reg   <= 1'b0;
                ctl_reg  <= 2'b00;
                data_reg <= 8'h00;
            end
        end
    end

    assign bitslip       = bitslip_reg;
    assign locked        = locked_reg;
    assign de            = de_reg;
    assign ctl           = ctl_reg;
    assign data          = data_reg;
    assign slip_cnt      = slip_cnt_reg;
    assign lock_loss_cnt = lock_loss_cnt_reg;

endmodule

// File: tb/tb_tmds_rx_decoder.sv
`timescale 1ns/1ps
module tb_tmds_rx_decoder;

    localparam int RUN_MIN = 8;
    localparam int ST      = 1024;
    localparam int SS      = 16;
    localparam int LT      = 2048;

    // model modes
    localparam int M_HUNT   = 0;
    localparam int M_SETTLE = 1;
    localparam int M_ALIGN  = 2;

    logic       clk_pixel = 1'b0;
    logic       rst_n     = 1'b0;
    logic [9:0] tmds_word = 10'd0;
    logic       bitslip, locked, de;
    logic [1:0] ctl;
    logic [7:0] data;
    logic [3:0] slip_cnt;
    logic [7:0] lock_loss_cnt;

    always #20 clk_pixel = ~clk_pixel;

    tmds_rx_decoder dut (
        .clk_pixel     (clk_pixel),
        .rst_n         (rst_n),
        .tmds_word     (tmds_word),
        .bitslip       (bitslip),
        .locked        (locked),
        .de            (de),
        .ctl           (ctl),
        .data          (data),
        .slip_cnt      (slip_cnt),
        .lock_loss_cnt (lock_loss_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [9:0] tok_tbl [4] = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};

    // reference model state
    int         m_mode, m_run, m_tmr, m_slip, m_loss;
    logic       e_bitslip, e_locked, e_de;
    logic [1:0] e_ctl;
    logic [7:0] e_data;
    int         enc_disp;

    // DVI transmit encoder (with running disparity); decoded data must return the byte.
    function automatic logic [9:0] tmds_encode(input logic [7:0] d);
        logic [8:0] qm;
        logic [9:0] w;
        int n1, n1q, n0q;
        n1 = $countones(d);
        qm[0] = d[0];
        if (n1 > 4 || (n1 == 4 && !d[0])) begin
            for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ d[i]);
            qm[8] = 1'b0;
        end else begin
            for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i];
            qm[8] = 1'b1;
        end
        n1q = $countones(qm[7:0]);
        n0q = 8 - n1q;
        if (enc_disp == 0 || n1q == n0q) begin
            w = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
            if (qm[8]) enc_disp += n1q - n0q;
            else       enc_disp += n0q - n1q;
        end else if ((enc_disp > 0 && n1q > n0q) || (enc_disp < 0 && n0q > n1q)) begin
            w = {1'b1, qm[8], ~qm[7:0]};
            enc_disp += 2 * int'(qm[8]) + n0q - n1q;
        end else begin
            w = {1'b0, qm[8], qm[7:0]};
            enc_disp += -2 * int'(!qm[8]) + n1q - n0q;
        end
        return w;
    endfunction

    function automatic void model_reset();
        m_mode = M_HUNT; m_run = 0; m_tmr = 0; m_slip = 0; m_loss = 0;
        e_bitslip = 0; e_locked = 0; e_de = 0; e_ctl = 0; e_data = 0;
    endfunction

    // One clock of the receiver as described behaviourally: pix is the byte that
    // was encoded into w (ignored for tokens).
    function automatic void model_step(input logic [9:0] w, input logic [7:0] pix);
        bit tok, hit;
        int val;
        tok = 0; val = 0;
        for (int i = 0; i < 4; i++) if (w == tok_tbl[i]) begin tok = 1; val = i; end
        hit = tok && (m_run == RUN_MIN - 1);
        if (m_mode == M_SETTLE || !tok) m_run = 0;
        else if (m_run < RUN_MIN) m_run++;
        e_bitslip = 0;
        if (m_mode == M_HUNT) begin
            if (hit) begin m_mode = M_ALIGN; m_tmr = 0; end
            else if (m_tmr == ST - 1) begin
                e_bitslip = 1; m_slip = (m_slip + 1) % 10; m_tmr = 0; m_mode = M_SETTLE; m_run = 0;
            end else m_tmr++;
        end else if (m_mode == M_SETTLE) begin
            if (m_tmr == SS - 1) begin m_mode = M_HUNT; m_tmr = 0; end
            else m_tmr++;
        end else begin
            if (hit) m_tmr = 0;
            else if (m_tmr == LT - 1) begin
                m_mode = M_HUNT; m_tmr = 0; if (m_loss < 255) m_loss++;
            end else m_tmr++;
        end
        e_locked = (m_mode == M_ALIGN);
        if (e_locked) begin
            if (tok) begin e_de = 0; e_ctl = 2'(val); end
            else begin e_de = 1; e_data = pix; end
        end else begin
            e_de = 0; e_ctl = 0; e_data = 0;
        end
    endfunction

    task automatic drive(input logic [9:0] w, input logic [7:0] pix);
        tmds_word = w;
        @(posedge clk_pixel);
        model_step(w, pix);
        #1;
    endtask

    task automatic send_data(input logic [7:0] pix);
        drive(tmds_encode(pix), pix);
    endtask

    task automatic send_ctrl(input int c);
        enc_disp = 0;
        drive(tok_tbl[c], 8'h00);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tmds_word = 10'd0;
        repeat (2) @(posedge clk_pixel);
        #1;
        model_reset();
        enc_disp = 0;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (bitslip !== 1'b0) begin n_fail++; $display("FAIL reset_bitslip got=%b exp=0", bitslip); end
        n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked got=%b exp=0", locked); end
        n_checks++; if (de !== 1'b0) begin n_fail++; $display("FAIL reset_de got=%b exp=0", de); end
        n_checks++; if (ctl !== 2'b00) begin n_fail++; $display("FAIL reset_ctl got=%b exp=00", ctl); end
        n_checks++; if (data !== 8'h00) begin n_fail++; $display("FAIL reset_data got=%h exp=00", data); end
        n_checks++; if (slip_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_slip_cnt got=%0d exp=0", slip_cnt); end
        n_checks++; if (lock_loss_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_lock_loss got=%0d exp=0", lock_loss_cnt); end
        $display("test_reset: outputs checked after reset");
    endtask

    task automatic test_aligned_loopback();
        logic [7:0] fixed [5] = '{8'h00, 8'h10, 8'hFF, 8'hA5, 8'h5A};
        logic [7:0] pix;
        int cyc = 0, lock_cyc = -1;
        do_reset();
        for (int line = 0; line < 3; line++) begin
            for (int i = 0; i < 160; i++) begin
                send_ctrl(0); cyc++;
                if (locked === 1'b1 && lock_cyc < 0) lock_cyc = cyc;
                n_checks++;
                if ({bitslip, locked, de, ctl, data, slip_cnt, lock_loss_cnt} !==
                    {e_bitslip, e_locked, e_de, e_ctl, e_data, 4'(m_slip), 8'(m_loss)}) begin
                    n_fail++;
                    $display("FAIL loopback_blank cyc=%0d got bs=%b lk=%b de=%b ctl=%b data=%h exp bs=%b lk=%b de=%b ctl=%b data=%h",
                             cyc, bitslip, locked, de, ctl, data, e_bitslip, e_locked, e_de, e_ctl, e_data);
                end
            end
            for (int i = 0; i < 40; i++) begin
                pix = (i < 5) ? fixed[i] : 8'($urandom_range(0, 255));
                send_data(pix); cyc++;
                if (i < 5) begin
                    n_checks++;
                    if (de !== 1'b1 || data !== pix) begin
                        n_fail++;
                        $display("FAIL loopback_byte line=%0d got de=%b data=%h exp de=1 data=%h", line, de, data, pix);
                    end
                end
                n_checks++;
                if ({bitslip, locked, de, ctl, data} !== {e_bitslip, e_locked, e_de, e_ctl, e_data}) begin
                    n_fail++;
                    $display("FAIL loopback_data cyc=%0d got lk=%b de=%b data=%h exp lk=%b de=%b data=%h",
                             cyc, locked, de, data, e_locked, e_de, e_data);
                end
            end
        end
        n_checks++;
        if (lock_cyc !== 8) begin n_fail++; $display("FAIL loopback_lock_cycle got=%0d exp=8", lock_cyc); end
        $display("test_aligned_loopback: %0d cycles, lock at cycle %0d", cyc, lock_cyc);
    endtask

    task automatic test_sync_decode();
        for (int i = 0; i < 20; i++) begin
            send_ctrl(1);
            n_checks++;
            if (de !== 1'b0 || ctl !== 2'b01 || locked !== 1'b1) begin
                n_fail++; $display("FAIL sync_hsync i=%0d got de=%b ctl=%b lk=%b exp de=0 ctl=01 lk=1", i, de, ctl, locked);
            end
        end
        for (int i = 0; i < 20; i++) begin
            send_ctrl(2);
            n_checks++;
            if (de !== 1'b0 || ctl !== 2'b10 || locked !== 1'b1) begin
                n_fail++; $display("FAIL sync_vsync i=%0d got de=%b ctl=%b lk=%b exp de=0 ctl=10 lk=1", i, de, ctl, locked);
            end
        end
        $display("test_sync_decode: hsync then vsync tokens decoded");
    endtask

    task automatic test_loss_of_lock();
        do_reset();
        for (int i = 0; i < RUN_MIN; i++) send_ctrl(0);
        n_checks++;
        if (locked !== 1'b1) begin n_fail++; $display("FAIL loss_initial_lock got=%b exp=1", locked); end
        for (int k = 1; k <= LT + 4; k++) begin
            send_data(8'h55);
            n_checks++;
            if ({locked, de, ctl, data, lock_loss_cnt} !== {e_locked, e_de, e_ctl, e_data, 8'(m_loss)}) begin
                n_fail++;
                $display("FAIL loss_model k=%0d got lk=%b de=%b data=%h llc=%0d exp lk=%b de=%b data=%h llc=%0d",
                         k, locked, de, data, lock_loss_cnt, e_locked, e_de, e_data, m_loss);
            end
            if (k == LT - 1) begin
                n_checks++;
                if (locked !== 1'b1) begin n_fail++; $display("FAIL loss_still_locked got=%b exp=1", locked); end
            end
            if (k == LT) begin
                n_checks++;
                if ({locked, de, ctl, data, lock_loss_cnt, bitslip} !== {1'b0, 1'b0, 2'b00, 8'h00, 8'd1, 1'b0}) begin
                    n_fail++;
                    $display("FAIL loss_unlock got lk=%b de=%b ctl=%b data=%h llc=%0d bs=%b exp lk=0 de=0 ctl=00 data=00 llc=1 bs=0",
                             locked, de, ctl, data, lock_loss_cnt, bitslip);
                end
            end
        end
        $display("test_loss_of_lock: lock_loss_cnt=%0d", lock_loss_cnt);
    endtask

    task automatic test_run_boundary();
        int step = 0;
        do_reset();
        for (int i = 0; i < 7; i++) begin send_ctrl(0); step++; end
        send_data(8'h3C); step++;
        for (int i = 0; i < 7; i++) begin send_ctrl(3); step++; end
        while (step < ST + 1) begin
            send_data(8'($urandom_range(0, 255))); step++;
            n_checks++;
            if (locked !== 1'b0) begin n_fail++; $display("FAIL boundary_no_lock step=%0d got=%b exp=0", step, locked); end
            if (step == ST - 1 || step == ST + 1) begin
                n_checks++;
                if (bitslip !== 1'b0) begin n_fail++; $display("FAIL boundary_quiet step=%0d got=%b exp=0", step, bitslip); end
            end
            if (step == ST) begin
                n_checks++;
                if (bitslip !== 1'b1 || slip_cnt !== 4'd1) begin
                    n_fail++; $display("FAIL boundary_slip got bs=%b slip=%0d exp bs=1 slip=1", bitslip, slip_cnt);
                end
            end
        end
        do_reset();
        for (int i = 0; i < ST - RUN_MIN; i++) send_data(8'($urandom_range(0, 255)));
        for (int i = 0; i < RUN_MIN; i++) send_ctrl(0);
        n_checks++;
        if ({locked, bitslip, slip_cnt} !== {1'b1, 1'b0, 4'd0}) begin
            n_fail++; $display("FAIL boundary_lock_on_timeout got lk=%b bs=%b slip=%0d exp lk=1 bs=0 slip=0", locked, bitslip, slip_cnt);
        end
        send_ctrl(0);
        n_checks++;
        if (bitslip !== 1'b0 || locked !== 1'b1) begin
            n_fail++; $display("FAIL boundary_after got bs=%b lk=%b exp bs=0 lk=1", bitslip, locked);
        end
        $display("test_run_boundary: short runs rejected, run on timeout cycle locked");
    endtask

    task automatic test_misaligned();
        int offset = 3;
        int pulses[$];
        logic [19:0] pair;
        int step = 0;
        do_reset();
        pair = {tok_tbl[0], tok_tbl[0]};
        while (step < 10000 && locked !== 1'b1) begin
            drive(pair[offset +: 10], 8'h00); step++;
            n_checks++;
            if ({bitslip, locked, slip_cnt} !== {e_bitslip, e_locked, 4'(m_slip)}) begin
                n_fail++;
                $display("FAIL misalign_model step=%0d got bs=%b lk=%b slip=%0d exp bs=%b lk=%b slip=%0d",
                         step, bitslip, locked, slip_cnt, e_bitslip, e_locked, m_slip);
            end
            if (bitslip === 1'b1) begin
                pulses.push_back(step);
                offset = (offset + 1) % 10;
            end
        end
        n_checks++;
        if (pulses.size() != 7) begin n_fail++; $display("FAIL misalign_pulse_count got=%0d exp=7", pulses.size()); end
        for (int i = 0; i < pulses.size(); i++) begin
            n_checks++;
            if (pulses[i] != ST + i * (ST + SS)) begin
                n_fail++; $display("FAIL misalign_pulse_time idx=%0d got=%0d exp=%0d", i, pulses[i], ST + i * (ST + SS));
            end
        end
        n_checks++;
        if (locked !== 1'b1 || slip_cnt !== 4'd7) begin
            n_fail++; $display("FAIL misalign_final got lk=%b slip=%0d exp lk=1 slip=7", locked, slip_cnt);
        end
        $display("test_misaligned: %0d pulses, locked after %0d cycles, slip_cnt=%0d", pulses.size(), step, slip_cnt);
    endtask

    task automatic test_reset_mid_slip();
        int step = 0;
        do_reset();
        while (step < ST + 50 && bitslip !== 1'b1) begin
            send_data(8'($urandom_range(0, 255))); step++;
        end
        for (int i = 0; i < 5; i++) send_data(8'h77);
        n_checks++;
        if (slip_cnt !== 4'd1) begin n_fail++; $display("FAIL midslip_pre got slip=%0d exp=1", slip_cnt); end
        #5 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bitslip, locked, de, ctl, data, slip_cnt, lock_loss_cnt} !== 25'd0) begin
            n_fail++; $display("FAIL midslip_async got bs=%b lk=%b slip=%0d exp all zero", bitslip, locked, slip_cnt);
        end
        repeat (2) @(posedge clk_pixel);
        #1;
        model_reset();
        enc_disp = 0;
        rst_n = 1'b1;
        n_checks++;
        if ({bitslip, locked, de, ctl, data, slip_cnt, lock_loss_cnt} !== 25'd0) begin
            n_fail++; $display("FAIL midslip_released got bs=%b lk=%b slip=%0d exp all zero", bitslip, locked, slip_cnt);
        end
        for (int i = 0; i < RUN_MIN; i++) begin
            send_ctrl(0);
            if (i == RUN_MIN - 2) begin
                n_checks++;
                if (locked !== 1'b0) begin n_fail++; $display("FAIL midslip_early_lock got=%b exp=0", locked); end
            end
        end
        n_checks++;
        if (locked !== 1'b1) begin n_fail++; $display("FAIL midslip_relock got=%b exp=1", locked); end
        $display("test_reset_mid_slip: relocked=%b", locked);
    endtask

    task automatic test_back_to_back();
        int cyc = 0;
        int blen, dlen, c;
        logic [7:0] pix;
        do_reset();
        while (cyc < 3000) begin
            blen = $urandom_range(1, 20);
            c = $urandom_range(0, 3);
            for (int i = 0; i < blen; i++) begin
                send_ctrl(c); cyc++;
                n_checks++;
                if ({bitslip, locked, de, ctl, data, slip_cnt, lock_loss_cnt} !==
                    {e_bitslip, e_locked, e_de, e_ctl, e_data, 4'(m_slip), 8'(m_loss)}) begin
                    n_fail++;
                    $display("FAIL random_blank cyc=%0d got lk=%b de=%b ctl=%b data=%h bs=%b exp lk=%b de=%b ctl=%b data=%h bs=%b",
                             cyc, locked, de, ctl, data, bitslip, e_locked, e_de, e_ctl, e_data, e_bitslip);
                end
            end
            dlen = $urandom_range(1, 60);
            for (int i = 0; i < dlen; i++) begin
                pix = 8'($urandom_range(0, 255));
                send_data(pix); cyc++;
                n_checks++;
                if ({bitslip, locked, de, ctl, data, slip_cnt, lock_loss_cnt} !==
                    {e_bitslip, e_locked, e_de, e_ctl, e_data, 4'(m_slip), 8'(m_loss)}) begin
                    n_fail++;
                    $display("FAIL random_data cyc=%0d got lk=%b de=%b ctl=%b data=%h bs=%b exp lk=%b de=%b ctl=%b data=%h bs=%b",
                             cyc, locked, de, ctl, data, bitslip, e_locked, e_de, e_ctl, e_data, e_bitslip);
                end
            end
        end
        $display("test_back_to_back: %0d random cycles", cyc);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        enc_disp = 0;
        test_reset();
        test_aligned_loopback();
        test_sync_decode();
        test_loss_of_lock();
        test_run_boundary();
        test_misaligned();
        test_reset_mid_slip();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
